// File: rtl/minutes_display_pkg.sv
// Shared types and constants for the minutes display driver: converter states,
// BCD nibble width and active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package minutes_display_pkg;

    localparam int BCD_W = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
    function automatic logic [BCD_W-1:0] add3_if_ge5(input logic [BCD_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [BCD_W-1:0] d);
        return (d <= 4'd9) ? SEG_DIGITS[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: 8-bit binary to hundreds/tens/ones,
// one bit per cycle, eight SHIFT cycles per conversion.
module bin2bcd_seq
    import minutes_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [7:0]       bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             err
);

    conv_state_t          state;
    logic [7:0]           shreg;
    logic [3*BCD_W-1:0]   scratch;
    logic [3*BCD_W-1:0]   scratch_adj;
    logic [3*BCD_W-1:0]   scratch_nxt;
    logic [2:0]           iter;

    always_comb begin
        scratch_adj = {add3_if_ge5(scratch[11:8]),
                       add3_if_ge5(scratch[7:4]),
                       add3_if_ge5(scratch[3:0])};
        scratch_nxt = {scratch_adj[10:0], shreg[7]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            scratch <= '0;
            iter    <= '0;
            tens    <= '0;
            ones    <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg   <= bin;
                        scratch <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[6:0], 1'b0};
                    scratch <= scratch_nxt;
                    iter    <= iter + 3'd1;
                    // The last shift lands directly in the result registers.
                    if (iter == 3'd7) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        tens  <= scratch_nxt[7:4];
                        ones  <= scratch_nxt[3:0];
                        err   <= (scratch_nxt[11:8] != 4'd0);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/minutes_display_driver.sv
// Minutes value to two-digit multiplexed active-low 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module minutes_display_driver
    import minutes_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       count_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             err,
    output logic [6:0]       seg_n,
    output logic [1:0]       an_n
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0] presc;
    logic             digit_sel;
    logic [6:0]       seg_nxt;
    logic [1:0]       an_nxt;

    // Handshake: load is a one-cycle request honoured only while busy is low
    // (busy acts as not-ready, nothing is queued); done marks bcd_*/err valid.
    bin2bcd_seq u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .bin  (count_in),
        .busy (busy),
        .done (done),
        .tens (bcd_tens),
        .ones (bcd_ones),
        .err  (err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            digit_sel <= 1'b0;
        end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
            presc     <= '0;
            digit_sel <= ~digit_sel;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        an_nxt  = digit_sel ? 2'b01 : 2'b10;
        seg_nxt = SEG_BLANK;
        if (err) begin
            seg_nxt = SEG_DASH;
        end else if (digit_sel) begin
`ifdef LEADING_ZERO_BLANK_EN
            seg_nxt = (bcd_tens == '0) ? SEG_BLANK : digit_seg(bcd_tens);
`else
            seg_nxt = digit_seg(bcd_tens);
`endif
        end else begin
            seg_nxt = digit_seg(bcd_ones);
        end
    end

    // Registering from the live digit select and digits keeps the outputs glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= SEG_BLANK;
            an_n  <= 2'b11;
        end else begin
            seg_n <= seg_nxt;
            an_n  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_minutes_display_driver.sv
// Directed bench for minutes_display_driver: scoreboarded conversions plus a
// cycle-by-cycle model of the scanned display.
module tb_minutes_display_driver;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] count_in = '0;
  logic       load = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       err;
  logic [6:0] seg_n;
  logic [1:0] an_n;

  minutes_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .err      (err),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [6:0] seg_tbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_val(input int v);
    int r;
    r = v % 100;
    return {(v > 99), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input bit tens_pos, input logic [8:0] m);
    if (m[8]) return 7'b0111111;
    if (tens_pos) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (m[7:4] == 4'd0) return 7'b1111111;
`endif
      return seg_tbl[m[7:4]];
    end
    return seg_tbl[m[3:0]];
  endfunction

  // ---------------- scoreboard / display monitor ----------------
  logic [8:0] m_disp = '0;
  logic [8:0] popped;
  logic       prev_done = 1'b0;
  bit         tens_pos;
  int         last_done_edge = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_disp    = '0;
      prev_done = 1'b0;
    end else begin
      if (edge_cnt == 0) begin
        check("seg_pre_edge", 16'(seg_n), 16'h7f);
        check("an_pre_edge", 16'(an_n), 16'h3);
      end else begin
        tens_pos = (((edge_cnt - 1) / SCAN_DIV) % 2) == 1;
        check("an_scan", 16'(an_n), tens_pos ? 16'h1 : 16'h2);
        check("seg_scan", 16'(seg_n), 16'(exp_seg(tens_pos, m_disp)));
      end
      if (done) begin
        check("done_width", 16'(prev_done), 16'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 16'(done), 16'h0);
        end else begin
          popped = exp_q.pop_front();
          check("bcd_result", 16'({err, bcd_tens, bcd_ones}), 16'(popped));
          m_disp = popped;
        end
        last_done_edge = edge_cnt;
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; load is sampled on the following rising edge.
  task automatic pulse_load(input int v, input bit accept);
    count_in = 8'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (accept) exp_q.push_back(ref_val(v));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_arrives", 16'(done), 16'h1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 16'(busy), 16'h0);
    check({tag, "_done"}, 16'(done), 16'h0);
    check({tag, "_bcd"}, 16'({err, bcd_tens, bcd_ones}), 16'h0);
    check({tag, "_seg"}, 16'(seg_n), 16'h7f);
    check({tag, "_an"}, 16'(an_n), 16'h3);
  endtask

  // ---------------- directed sequence ----------------
  int t0;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_edge_an", 16'(an_n), 16'h2);
    check("first_edge_seg", 16'(seg_n), 16'h40);
    @(negedge clk);

    // 59: busy for the eight shift cycles, done once, then scanning 5/9
    pulse_load(59, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("busy_59", 16'(busy), 16'h1);
      check("no_early_done_59", 16'(done), 16'h0);
      @(negedge clk);
    end
    check("done_59", 16'(done), 16'h1);
    check("busy_low_59", 16'(busy), 16'h0);
    @(negedge clk);
    check("done_fall_59", 16'(done), 16'h0);
    repeat (12) @(negedge clk);

    // out of range, then single digit (leading zero case)
    pulse_load(100, 1'b1);
    wait_done();
    repeat (10) @(negedge clk);
    pulse_load(7, 1'b1);
    wait_done();
    repeat (10) @(negedge clk);

    // load while busy is dropped; load in the done cycle is taken
    pulse_load(42, 1'b1);
    repeat (2) @(negedge clk);
    pulse_load(99, 1'b0);
    check("busy_after_ignored", 16'(busy), 16'h1);
    wait_done();
    t0 = edge_cnt;
    pulse_load(99, 1'b1);
    wait_done();
    check("done_cycle_load_spacing", 16'(edge_cnt - t0), 16'd9);
    repeat (4) @(negedge clk);

    // back-to-back 0 then 99
    pulse_load(0, 1'b1);
    wait_done();
    t0 = edge_cnt;
    pulse_load(99, 1'b1);
    wait_done();
    check("b2b_spacing", 16'(edge_cnt - t0), 16'd9);
    repeat (4) @(negedge clk);

    // reset in the middle of converting 88: no result may appear
    pulse_load(88, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_an", 16'(an_n), 16'h2);
    check("post_reset_seg", 16'(seg_n), 16'h40);
    check("post_reset_busy", 16'(busy), 16'h0);
    @(negedge clk);

    // every 8-bit value, each loaded in the previous done cycle
    for (int v = 0; v < 256; v++) begin
      pulse_load(v, 1'b1);
      wait_done();
    end
    repeat (12) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
